instr_mem_loader: RTL
=====================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter IW, default 4, meaning log2 of instruction-memory depth in 32-bit words (2**IW words, 2**(IW+2) bytes).
REQ-002 SHALL have port Clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, single-cycle request to begin a program load.
REQ-005 SHALL have port byte_in, input, 8, incoming program byte.
REQ-006 SHALL have port byte_valid, input, 1, byte_in holds a valid byte.
REQ-007 SHALL have port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-008 SHALL have port wr_en, output, 1, instruction-memory word write strobe.
REQ-009 SHALL have port wr_addr, output, IW, word address of the write.
REQ-010 SHALL have port wr_data, output, 32, assembled instruction word.
REQ-011 SHALL have port cpu_hold, output, 1, holds the processor off while loading.
REQ-012 SHALL have port done, output, 1, load complete.
REQ-013 SHALL have port error, output, 1, checksum failure flag.
REQ-014 SHALL have port word_count, output, IW+1, number of words written in the current load.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WRITE, DONE, plus CHECK when the checksum feature is compiled in.
REQ-016 SHALL move IDLE->LOAD or DONE->LOAD on start=1, clearing word index, byte lane, word_count, error and checksum accumulator.
REQ-017 SHALL ignore start while in LOAD, WRITE or CHECK.
REQ-018 SHALL drive byte_ready=1 only in LOAD and CHECK; a byte transfers only on a cycle with byte_valid=1 and byte_ready=1.
REQ-019 SHALL place lane 0,1,2,3 bytes into wr_data[31:24],[23:16],[15:8],[7:0] respectively (first byte most significant).
REQ-020 SHALL, on the 4th byte transfer of a word, enter WRITE; in WRITE wr_en=1 for exactly one cycle, with wr_addr equal to the word index and wr_data equal to the complete word.
REQ-021 SHALL keep wr_en=0 in all states other than WRITE; wr_addr and wr_data hold their last values otherwise.
REQ-022 SHALL increment word_count in the WRITE cycle, reaching 2**IW after the last word, and hold that value until the next start.
REQ-023 SHALL return WRITE->LOAD when the word index is below 2**IW-1, otherwise go to DONE (or CHECK when compiled in).
REQ-024 SHALL drive cpu_hold=1 in LOAD, WRITE and CHECK, and 0 in IDLE and DONE.
REQ-025 SHALL drive done=1 only in DONE.
REQ-026 SHALL tolerate arbitrary byte_valid gaps with no effect on lane or word state.

Reset
REQ-027 SHALL, on Reset=1 at any time, including mid-load, immediately enter IDLE with byte_ready, wr_en, cpu_hold, done and error at 0, and wr_addr, wr_data, word_count, lane and accumulator at 0.
REQ-028 SHALL never complete a partially assembled word after reset.

Configuration
REQ-029 SHALL, when macro LOADER_CHECKSUM_EN is defined, sum every accepted byte modulo 256, accept one extra checksum byte in CHECK, then enter DONE with error=1 if the 8-bit sum of all bytes including the checksum byte is nonzero.
REQ-030 SHALL keep error sticky until the next start or Reset.
REQ-031 SHALL, when LOADER_CHECKSUM_EN is undefined, omit CHECK, go WRITE->DONE after the last word, and tie error to 0.

Verification
REQ-032 SHALL cover: IW=4, start, 64 bytes 0x00..0x3F with byte_valid held high -> 16 wr_en pulses; addr 0 data 0x00010203; addr 15 data 0x3C3D3E3F; word_count=16; done=1; cpu_hold=0.
REQ-033 SHALL cover: same stream with byte_valid low every other cycle -> identical writes, and byte_ready=0 during each WRITE cycle.
REQ-034 SHALL cover: Reset pulse after 10 bytes, then start and 64 bytes 0xFF -> first write is addr 0 data 0xFFFFFFFF; no write is produced from the pre-reset bytes.
REQ-035 SHALL cover: start asserted after 5 words loaded -> no restart; load finishes with word_count=16.
REQ-036 SHALL cover, with LOADER_CHECKSUM_EN: bytes 0x00..0x3F (sum 0xE0), then checksum 0x20 -> done=1, error=0; then checksum 0x21 -> done=1, error=1.
REQ-037 SHALL cover: after done, a second start -> word_count=0, done=0, cpu_hold=1 on the next cycle.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a byte stream into 32-bit words and writes them to instruction memory
// Define LOADER_CHECKSUM_EN to add a trailing checksum byte (CHECK state) that sets error.
module instr_mem_loader #(
  parameter int IW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [IW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [IW:0]   word_count
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
  logic [7:0] acc;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
  assign error = 1'b0;
`endif
  state_t state;
  logic [IW-1:0] idx;
  logic [1:0] lane;
  logic [23:0] word;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      byte_ready <= 1'b0;
      wr_en <= 1'b0;
      cpu_hold <= 1'b0;
      done <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      word_count <= '0;
      idx <= '0;
      lane <= '0;
      word <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc <= '0;
      error <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state <= LOAD;
          idx <= '0;
          lane <= '0;
          word_count <= '0;
          byte_ready <= 1'b1;
          cpu_hold <= 1'b1;
          done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
          acc <= '0;
          error <= 1'b0;
`endif
        end
        LOAD: if (byte_valid) begin
          lane <= lane + 2'd1;
          word <= {word[15:0], byte_in};
`ifdef LOADER_CHECKSUM_EN
          acc <= acc + byte_in;
`endif
          // Fourth byte completes the word: latch it into the write port
          if (lane == 2'd3) begin
            state <= WRITE;
            wr_en <= 1'b1;
            wr_addr <= idx;
            wr_data <= {word, byte_in};
            byte_ready <= 1'b0;
          end
        end
        WRITE: begin
          word_count <= word_count + 1'b1;
          idx <= idx + 1'b1;
          if (idx != '1) begin
            state <= LOAD;
            byte_ready <= 1'b1;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state <= CHECK;
            byte_ready <= 1'b1;
`else
            state <= DONE;
            cpu_hold <= 1'b0;
            done <= 1'b1;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: if (byte_valid) begin
          state <= DONE;
          error <= (acc + byte_in) != 8'd0;
          byte_ready <= 1'b0;
          cpu_hold <= 1'b0;
          done <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
